// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - UART transmitter with TX FIFO, runtime divisor, parity and 1/2 stop bits
module uart_tx_fifo #(
   parameter int PAYLOAD_BITS = 8,
   parameter int FIFO_DEPTH   = 8,
   parameter int CLK_HZ       = 50_000_000,
   parameter int BIT_RATE     = 115200,
   parameter int DIV_W        = 16
) (
   input  logic                        clk,
   input  logic                        resetn,
   input  logic [PAYLOAD_BITS-1:0]     uart_tx_data,
   input  logic                        uart_tx_en,
   output logic                        uart_tx_ready,
   output logic                        uart_tx_overflow,
   output logic                        uart_tx_busy,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level,
   input  logic [DIV_W-1:0]            cfg_div,
   input  logic [1:0]                  cfg_parity,
   input  logic                        cfg_stop2,
   output logic                        uart_txd
);

   localparam int PTR_W   = $clog2(FIFO_DEPTH);
   localparam int LVL_W   = PTR_W + 1;
   localparam int BIT_W   = (PAYLOAD_BITS > 1) ? $clog2(PAYLOAD_BITS) : 1;
   localparam int DEF_DIV = CLK_HZ / BIT_RATE;

   localparam logic [DIV_W-1:0] DEF_DIV_V = DIV_W'(DEF_DIV);
   localparam logic [LVL_W-1:0] DEPTH_V   = LVL_W'(FIFO_DEPTH);
   localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(PAYLOAD_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   // ---------------------------------------------------------------------
   // TX FIFO
   // ---------------------------------------------------------------------
   logic [PAYLOAD_BITS-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]        wr_ptr;
   logic [PTR_W-1:0]        rd_ptr;
   logic [LVL_W-1:0]        level_q;
   logic [LVL_W-1:0]        level_n;
   logic                    full_q;
   logic                    ovf_q;
   logic                    push;
   logic                    pop;
   logic                    empty;
   logic [PAYLOAD_BITS-1:0] head;

   // ready comes from the registered full flag, so a same-cycle pop never rescues a write
   assign push             = uart_tx_en && !full_q;
   assign empty            = (level_q == '0);
   assign head             = mem[rd_ptr];
   assign uart_tx_ready    = !full_q;
   assign uart_tx_overflow = ovf_q;
   assign fifo_level       = level_q;

   // Storage array: written on accepted pushes only
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= uart_tx_data;
      end
   end

   // Occupancy after this cycle's push/pop
   always_comb begin
      level_n = level_q;
      case ({push, pop})
         2'b10:   level_n = level_q + LVL_W'(1);
         2'b01:   level_n = level_q - LVL_W'(1);
         default: level_n = level_q;
      endcase
   end

   // Pointers, level, full flag and overflow pulse
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level_q <= '0;
         full_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         level_q <= level_n;
         full_q  <= (level_n == DEPTH_V);
         ovf_q   <= uart_tx_en && full_q;
      end
   end

   // ---------------------------------------------------------------------
   // Transmit FSM
   // ---------------------------------------------------------------------
   state_t                  state;
   state_t                  state_n;
   logic [DIV_W-1:0]        cnt;
   logic [DIV_W-1:0]        cnt_n;
   logic [DIV_W-1:0]        div_q;
   logic [DIV_W-1:0]        div_n;
   logic [DIV_W-1:0]        div_res;
   logic [BIT_W-1:0]        bit_idx;
   logic [BIT_W-1:0]        bit_idx_n;
   logic [PAYLOAD_BITS-1:0] shift_q;
   logic [PAYLOAD_BITS-1:0] shift_n;
   logic [PAYLOAD_BITS-1:0] data_q;
   logic [PAYLOAD_BITS-1:0] data_n;
   logic                    par_en_q;
   logic                    par_en_n;
   logic                    par_odd_q;
   logic                    par_odd_n;
   logic                    stop2_q;
   logic                    stop2_n;
   logic                    stop_second;
   logic                    stop_second_n;
   logic                    bit_end;
   logic                    load;
   logic                    txd_n;

   // 0 selects the build-time default; 1 is promoted to 2 so a bit is never a single cycle
   always_comb begin
      div_res = cfg_div;
      if (cfg_div == '0) begin
         div_res = DEF_DIV_V;
      end else if (cfg_div == DIV_W'(1)) begin
         div_res = DIV_W'(2);
      end
   end

   assign bit_end      = (cnt == div_q - DIV_W'(1));
   assign uart_tx_busy = !empty || (state != S_IDLE);

   // Next state, bit timing, FIFO pop and the next serial line level
   always_comb begin
      state_n       = state;
      cnt_n         = cnt;
      div_n         = div_q;
      bit_idx_n     = bit_idx;
      shift_n       = shift_q;
      data_n        = data_q;
      par_en_n      = par_en_q;
      par_odd_n     = par_odd_q;
      stop2_n       = stop2_q;
      stop_second_n = stop_second;
      load          = 1'b0;
      pop           = 1'b0;
      txd_n         = 1'b1;

      case (state)
         S_IDLE: begin
            cnt_n = '0;
            if (!empty) begin
               load = 1'b1;
            end
         end
         S_START: begin
            if (bit_end) begin
               cnt_n     = '0;
               bit_idx_n = '0;
               state_n   = S_DATA;
            end else begin
               cnt_n = cnt + DIV_W'(1);
            end
         end
         S_DATA: begin
            if (bit_end) begin
               cnt_n   = '0;
               shift_n = shift_q >> 1;
               if (bit_idx == LAST_BIT) begin
                  stop_second_n = 1'b0;
                  state_n       = par_en_q ? S_PARITY : S_STOP;
               end else begin
                  bit_idx_n = bit_idx + BIT_W'(1);
               end
            end else begin
               cnt_n = cnt + DIV_W'(1);
            end
         end
         S_PARITY: begin
            if (bit_end) begin
               cnt_n         = '0;
               stop_second_n = 1'b0;
               state_n       = S_STOP;
            end else begin
               cnt_n = cnt + DIV_W'(1);
            end
         end
         S_STOP: begin
            if (bit_end) begin
               cnt_n = '0;
               if (stop2_q && !stop_second) begin
                  stop_second_n = 1'b1;
               end else if (!empty) begin
                  load = 1'b1;
               end else begin
                  state_n = S_IDLE;
               end
            end else begin
               cnt_n = cnt + DIV_W'(1);
            end
         end
         default: begin
            state_n = S_IDLE;
            cnt_n   = '0;
         end
      endcase

      // Frame setup: configuration is captured only here, so mid-frame changes wait a frame
      if (load) begin
         pop           = 1'b1;
         shift_n       = head;
         data_n        = head;
         div_n         = div_res;
         par_en_n      = cfg_parity[0] ^ cfg_parity[1];
         par_odd_n     = (cfg_parity == 2'b10);
         stop2_n       = cfg_stop2;
         stop_second_n = 1'b0;
         cnt_n         = '0;
         state_n       = S_START;
      end

      case (state_n)
         S_START:  txd_n = 1'b0;
         S_DATA:   txd_n = shift_n[0];
         S_PARITY: txd_n = par_odd_n ? ~^data_n : ^data_n;
         default:  txd_n = 1'b1;
      endcase
   end

   // State, frame registers and the registered serial output
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state       <= S_IDLE;
         cnt         <= '0;
         div_q       <= DEF_DIV_V;
         bit_idx     <= '0;
         shift_q     <= '0;
         data_q      <= '0;
         par_en_q    <= 1'b0;
         par_odd_q   <= 1'b0;
         stop2_q     <= 1'b0;
         stop_second <= 1'b0;
         uart_txd    <= 1'b1;
      end else begin
         state       <= state_n;
         cnt         <= cnt_n;
         div_q       <= div_n;
         bit_idx     <= bit_idx_n;
         shift_q     <= shift_n;
         data_q      <= data_n;
         par_en_q    <= par_en_n;
         par_odd_q   <= par_odd_n;
         stop2_q     <= stop2_n;
         stop_second <= stop_second_n;
         uart_txd    <= txd_n;
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - directed self-checking bench for uart_tx_fifo
module tb_uart_tx_fifo;

   logic        clk = 1'b0;
   logic        resetn;
   logic [7:0]  uart_tx_data;
   logic        uart_tx_en;
   logic        uart_tx_ready;
   logic        uart_tx_overflow;
   logic        uart_tx_busy;
   logic [3:0]  fifo_level;
   logic [15:0] cfg_div;
   logic [1:0]  cfg_parity;
   logic        cfg_stop2;
   logic        uart_txd;

   int n_tests = 0;
   int n_fail  = 0;

   uart_tx_fifo dut (
      .clk              (clk),
      .resetn           (resetn),
      .uart_tx_data     (uart_tx_data),
      .uart_tx_en       (uart_tx_en),
      .uart_tx_ready    (uart_tx_ready),
      .uart_tx_overflow (uart_tx_overflow),
      .uart_tx_busy     (uart_tx_busy),
      .fifo_level       (fifo_level),
      .cfg_div          (cfg_div),
      .cfg_parity       (cfg_parity),
      .cfg_stop2        (cfg_stop2),
      .uart_txd         (uart_txd)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic write_word(input logic [7:0] d);
      @(posedge clk);
      #1;
      uart_tx_en   = 1'b1;
      uart_tx_data = d;
      @(posedge clk);
      #1;
      uart_tx_en = 1'b0;
   endtask

   // Waits for the start bit, then requires every cycle of every bit to match exp[i]
   task automatic check_frame(input string tag, input logic [15:0] exp, input int n, input int d,
                              output int gap, output logic busy_last);
      int waited;
      int good;
      waited = 0;
      busy_last = 1'b0;
      do begin
         @(negedge clk);
         waited++;
      end while (uart_txd !== 1'b0 && waited < 4000);
      gap = waited;
      if (uart_txd !== 1'b0) begin
         check($sformatf("%s start timeout", tag), uart_txd, 0);
         return;
      end
      for (int i = 0; i < n; i++) begin
         good = 0;
         for (int c = 0; c < d; c++) begin
            if (i > 0 || c > 0) @(negedge clk);
            if (uart_txd === exp[i]) good++;
         end
         check($sformatf("%s bit%0d cycles", tag, i), good, d);
      end
      busy_last = uart_tx_busy;
   endtask

   initial begin
      int         gap;
      logic       bl;
      int         ovf;
      int         hi;
      int         nb;
      logic [7:0] dv;

      resetn       = 1'b0;
      uart_tx_en   = 1'b0;
      uart_tx_data = 8'h00;
      cfg_div      = 16'd0;
      cfg_parity   = 2'b00;
      cfg_stop2    = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst txd", uart_txd, 1);
      check("rst ready", uart_tx_ready, 1);
      check("rst overflow", uart_tx_overflow, 0);
      check("rst busy", uart_tx_busy, 0);
      check("rst level", fifo_level, 0);
      resetn = 1'b1;
      repeat (2) @(negedge clk);
      check("idle txd", uart_txd, 1);

      // 1: default divisor 434, 8N1, 0x55
      write_word(8'h55);
      check_frame("t1", 16'h02AA, 10, 434, gap, bl);
      check("t1 busy last", bl, 1);
      @(negedge clk);
      check("t1 busy end", uart_tx_busy, 0);
      check("t1 txd end", uart_txd, 1);

      // 2: div 10, even parity, two stops, 0x07
      cfg_div = 16'd10; cfg_parity = 2'b01; cfg_stop2 = 1'b1;
      write_word(8'h07);
      check_frame("t2", 16'h0E0E, 12, 10, gap, bl);
      @(negedge clk);
      check("t2 busy end", uart_tx_busy, 0);

      // 3: odd parity, then parity code 11 meaning none
      cfg_parity = 2'b10;
      write_word(8'h07);
      check_frame("t3 odd", 16'h0C0E, 12, 10, gap, bl);
      @(negedge clk);
      check("t3 odd busy end", uart_tx_busy, 0);
      cfg_parity = 2'b11;
      write_word(8'h07);
      check_frame("t3 none", 16'h060E, 11, 10, gap, bl);
      @(negedge clk);
      check("t3 none busy end", uart_tx_busy, 0);

      // divisor 1 is promoted to 2 clocks per bit
      cfg_div = 16'd1; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
      write_word(8'h00);
      check_frame("div1", 16'h0200, 10, 2, gap, bl);
      @(negedge clk);
      check("div1 busy end", uart_tx_busy, 0);

      // 4: 12 back-to-back writes at div 4
      cfg_div = 16'd4;
      fork
         begin
            ovf = 0;
            for (int i = 0; i < 12; i++) begin
               @(posedge clk);
               #1;
               uart_tx_en   = 1'b1;
               uart_tx_data = 8'(8'h10 + i);
               @(negedge clk);
               ovf += int'(uart_tx_overflow);
            end
            @(posedge clk);
            #1;
            uart_tx_en = 1'b0;
            @(negedge clk);
            ovf += int'(uart_tx_overflow);
            check("t4 level full", fifo_level, 8);
            check("t4 ready full", uart_tx_ready, 0);
            @(negedge clk);
            ovf += int'(uart_tx_overflow);
            check("t4 overflow count", ovf, 3);
         end
         begin
            for (int k = 0; k < 9; k++) begin
               dv = 8'(8'h10 + k);
               check_frame($sformatf("t4 f%0d", k), 16'({1'b1, dv, 1'b0}), 10, 4, gap, bl);
               if (k > 0) check($sformatf("t4 gap f%0d", k), gap, 1);
            end
            @(negedge clk);
            check("t4 busy end", uart_tx_busy, 0);
            check("t4 level end", fifo_level, 0);
            check("t4 ready end", uart_tx_ready, 1);
         end
      join

      // 5: divisor change mid-frame only affects the following frame
      cfg_div = 16'd4;
      fork
         begin
            @(posedge clk);
            #1;
            uart_tx_en = 1'b1; uart_tx_data = 8'hA5;
            @(posedge clk);
            #1;
            uart_tx_data = 8'h3C;
            @(posedge clk);
            #1;
            uart_tx_en = 1'b0;
            repeat (12) @(posedge clk);
            #1;
            cfg_div = 16'd8;
         end
         begin
            check_frame("t5 f0", 16'h034A, 10, 4, gap, bl);
            check_frame("t5 f1", 16'h0278, 10, 8, gap, bl);
            check("t5 gap", gap, 1);
            @(negedge clk);
            check("t5 busy end", uart_tx_busy, 0);
         end
      join

      // 6: asynchronous reset in data bit 3 with two words queued
      @(posedge clk);
      #1;
      uart_tx_en = 1'b1; uart_tx_data = 8'hF7;
      @(posedge clk);
      #1;
      uart_tx_data = 8'h11;
      @(posedge clk);
      #1;
      uart_tx_data = 8'h22;
      @(posedge clk);
      #1;
      uart_tx_en = 1'b0;
      repeat (33) @(negedge clk);
      check("t6 pre txd", uart_txd, 0);
      check("t6 pre level", fifo_level, 2);
      #2;
      resetn = 1'b0;
      #1;
      check("t6 rst txd", uart_txd, 1);
      check("t6 rst busy", uart_tx_busy, 0);
      check("t6 rst level", fifo_level, 0);
      check("t6 rst ready", uart_tx_ready, 1);
      @(posedge clk);
      #1;
      resetn = 1'b1;
      hi = 0;
      nb = 0;
      for (int c = 0; c < 300; c++) begin
         @(negedge clk);
         if (uart_txd === 1'b1) hi++;
         if (uart_tx_busy === 1'b0) nb++;
      end
      check("t6 txd stays high", hi, 300);
      check("t6 busy stays low", nb, 300);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
